led_pulse_driver: RTL
=====================

LED_PULSE_DRIVER -- requirements
Module: led_pulse_driver

Interface
REQ-001 Parameter: LANES, default 4, number of note-lane LEDs.
REQ-002 Parameter: HOLD_CYCLES, default 800000, full-brightness on-time in clk cycles (>=2).
REQ-003 Parameter: FADE_STEP_CYCLES, default 100000, cycles per fade brightness level (>=1).
REQ-004 Port: clk  input  1  system clock, rising edge.
REQ-005 Port: n_rst  input  1  asynchronous, active-low reset.
REQ-006 Port: mode  input  3  game mode; block active only when mode == 3'd4.
REQ-007 Port: hit  input  LANES  one-cycle hit pulses per lane, synchronous to clk.
REQ-008 Port: miss  input  1  one-cycle miss pulse.
REQ-009 Port: led  output  LANES  per-lane LED drive, registered.
REQ-010 Port: miss_led  output  1  miss indicator LED drive, registered.
REQ-011 Port: busy  output  1  high while any lane or the miss channel is not IDLE, registered.

Function
REQ-012 Each of the LANES+1 channels (lanes plus miss) SHALL run an independent FSM with states IDLE, ON, FADE.
REQ-013 IDLE: output 0; trigger pulse with mode==4 -> ON, hold counter cleared to 0.
REQ-014 Latency: trigger sampled at edge N -> output high from edge N+1; no added latency.
REQ-015 ON: output 1; counter increments each cycle; at count HOLD_CYCLES-1 -> FADE, level=7, step counter 0; output high exactly HOLD_CYCLES cycles.
REQ-016 FADE: output = (pwm_cnt < level); a 3-bit free-running pwm_cnt shared by all channels; level decrements every FADE_STEP_CYCLES; leaving level 1 -> IDLE.
REQ-017 Retrigger in ON or FADE (including the last cycle of either) SHALL restart ON with the counter at 0; the retrigger wins over the pending transition.
REQ-018 Triggers arriving while mode != 4 SHALL be ignored.
REQ-019 mode leaving 4 mid-operation: all channels SHALL go IDLE at the next edge, outputs 0; no resume when mode returns.
REQ-020 Simultaneous triggers on several channels SHALL each be honoured independently in the same cycle.
REQ-021 Counters SHALL be sized by $clog2 of their parameter and SHALL never wrap; terminal compare only.

Reset
REQ-022 n_rst low SHALL force all FSMs to IDLE and clear all counters, pwm_cnt, led, miss_led and busy to 0, asynchronously.
REQ-023 Reset release SHALL require a fresh trigger; pulses present during reset SHALL be lost.

Configuration
REQ-024 Macro LED_FADE_EN defined: FADE state and PWM logic SHALL be present as in REQ-016.
REQ-025 LED_FADE_EN undefined: ON SHALL go directly to IDLE after HOLD_CYCLES; the FADE state, level counter and pwm_cnt SHALL be absent.

Structure
REQ-026 Package led_pkg SHALL hold the channel state enum (IDLE, ON, FADE), the PWM width constant (3) and the fade start level (7).
REQ-027 Sub-module led_channel SHALL implement one FSM plus counters; the top SHALL instantiate it LANES+1 times and own pwm_cnt, mode gating and busy.

Verification (HOLD_CYCLES=10, FADE_STEP_CYCLES=4, LED_FADE_EN defined unless stated)
REQ-028 mode=4, hit[0] pulse at cycle 5 -> led[0]=1 for cycles 6..15; FADE levels 7..1 for 28 cycles; IDLE at 44; busy mirrors this.
REQ-029 hit[2] again at cycle 12 during ON -> led[2] high through cycle 22, then FADE.
REQ-030 mode=3, hit=4'hF and miss pulsed -> led, miss_led and busy stay 0.
REQ-031 hit[1] in ON, mode switched to 0 at cycle 8 -> led[1]=0 and busy=0 from cycle 9.
REQ-032 n_rst asserted mid-FADE -> all outputs 0 immediately; after release, a single miss pulse -> miss_led high for 10 cycles.
REQ-033 LED_FADE_EN undefined, hit[3] at cycle 0 -> led[3]=1 for cycles 1..10, 0 at cycle 11, busy=0 at 11.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the note-lane LED pulse driver.
// Optional fade behaviour is selected by the LED_FADE_EN macro.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    FADE = 2'd2
  } chan_state_e;

  localparam int          PWM_W       = 3;
  localparam logic [2:0]  FADE_START  = 3'd7;
  localparam logic [2:0]  MODE_ACTIVE = 3'd4;

endpackage

// File: rtl/led_channel.sv
// One LED channel: IDLE/ON/FADE state machine with hold, step and level counters.
// Fade state and PWM comparison exist only when LED_FADE_EN is defined.
module led_channel
  import led_pkg::*;
#(
  parameter int HOLD_CYCLES      = 800000,
  parameter int FADE_STEP_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  input  logic             trig,
`ifdef LED_FADE_EN
  input  logic [PWM_W-1:0] pwm_nxt,
`endif
  output logic             pulse,
  output logic             active_nxt
);

  localparam int            HW        = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO = HW'(0);

  chan_state_e   state_r, state_nxt_s;
  logic [HW-1:0] hold_r, hold_nxt_s;
  logic          pulse_r, pulse_nxt_s;

`ifdef LED_FADE_EN
  localparam int            SW        = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(FADE_STEP_CYCLES - 1);
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);
  localparam logic [SW-1:0] STEP_ZERO = SW'(0);

  logic [SW-1:0]    step_r, step_nxt_s;
  logic [PWM_W-1:0] level_r, level_nxt_s;
`endif

  // Next-state and counter logic; mode loss beats retrigger, retrigger beats any timeout.
  always_comb begin
    state_nxt_s = state_r;
    hold_nxt_s  = hold_r;
`ifdef LED_FADE_EN
    step_nxt_s  = step_r;
    level_nxt_s = level_r;
`endif
    if (!enable) begin
      state_nxt_s = IDLE;
      hold_nxt_s  = HOLD_ZERO;
    end else if (trig) begin
      state_nxt_s = ON;
      hold_nxt_s  = HOLD_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        ON: begin
          if (hold_r == HOLD_LAST) begin
            hold_nxt_s  = HOLD_ZERO;
`ifdef LED_FADE_EN
            state_nxt_s = FADE;
            level_nxt_s = FADE_START;
            step_nxt_s  = STEP_ZERO;
`else
            state_nxt_s = IDLE;
`endif
          end else begin
            hold_nxt_s = hold_r + HOLD_ONE;
          end
        end
`ifdef LED_FADE_EN
        FADE: begin
          if (step_r == STEP_LAST) begin
            step_nxt_s = STEP_ZERO;
            if (level_r == 3'd1) begin
              state_nxt_s = IDLE;
              level_nxt_s = 3'd0;
            end else begin
              level_nxt_s = level_r - 3'd1;
            end
          end else begin
            step_nxt_s = step_r + STEP_ONE;
          end
        end
`endif
        default: begin
          state_nxt_s = IDLE;
          hold_nxt_s  = HOLD_ZERO;
        end
      endcase
    end
  end

  // Output drive is computed from next-cycle values so the registered LED has no extra lag.
  always_comb begin
    pulse_nxt_s = 1'b0;
    if (state_nxt_s == ON) begin
      pulse_nxt_s = 1'b1;
`ifdef LED_FADE_EN
    end else if (state_nxt_s == FADE) begin
      pulse_nxt_s = (pwm_nxt < level_nxt_s);
`endif
    end else begin
      pulse_nxt_s = 1'b0;
    end
  end

  // Channel state, counters and LED register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
      hold_r  <= HOLD_ZERO;
      pulse_r <= 1'b0;
`ifdef LED_FADE_EN
      step_r  <= STEP_ZERO;
      level_r <= 3'd0;
`endif
    end else begin
      state_r <= state_nxt_s;
      hold_r  <= hold_nxt_s;
      pulse_r <= pulse_nxt_s;
`ifdef LED_FADE_EN
      step_r  <= step_nxt_s;
      level_r <= level_nxt_s;
`endif
    end
  end

  assign pulse      = pulse_r;
  assign active_nxt = (state_nxt_s != IDLE);

endmodule

// File: rtl/led_pulse_driver.sv
// LED pulse driver: LANES hit channels plus one miss channel, gated by game mode 4.
// LED_FADE_EN adds the PWM fade-out tail after the full-brightness hold.
module led_pulse_driver
  import led_pkg::*;
#(
  parameter int LANES            = 4,
  parameter int HOLD_CYCLES      = 800000,
  parameter int FADE_STEP_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [2:0]       mode,
  input  logic [LANES-1:0] hit,
  input  logic             miss,
  output logic [LANES-1:0] led,
  output logic             miss_led,
  output logic             busy
);

  localparam int CH = LANES + 1;

  logic          mode_ok_s;
  logic [CH-1:0] trig_s;
  logic [CH-1:0] pulse_s;
  logic [CH-1:0] act_nxt_s;
  logic          busy_r;

  assign mode_ok_s = (mode == MODE_ACTIVE);
  assign trig_s    = {miss, hit} & {CH{mode_ok_s}};

`ifdef LED_FADE_EN
  logic [PWM_W-1:0] pwm_r, pwm_nxt_s;

  assign pwm_nxt_s = pwm_r + 3'd1;

  // Free-running PWM phase shared by every channel.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pwm_r <= 3'd0;
    end else begin
      pwm_r <= pwm_nxt_s;
    end
  end
`endif

  for (genvar g = 0; g < CH; g++) begin : g_chan
    led_channel #(
      .HOLD_CYCLES      (HOLD_CYCLES),
      .FADE_STEP_CYCLES (FADE_STEP_CYCLES)
    ) u_chan (
      .clk        (clk),
      .n_rst      (n_rst),
      .enable     (mode_ok_s),
      .trig       (trig_s[g]),
`ifdef LED_FADE_EN
      .pwm_nxt    (pwm_nxt_s),
`endif
      .pulse      (pulse_s[g]),
      .active_nxt (act_nxt_s[g])
    );
  end

  // Busy flag registered alongside the channel states it summarises.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= |act_nxt_s;
    end
  end

  assign led      = pulse_s[LANES-1:0];
  assign miss_led = pulse_s[LANES];
  assign busy     = busy_r;

endmodule
